// File: rtl/pwm_multi_timer.sv
// Multi-channel PWM/timer: shared prescaler, shadowed period/duty per channel,
// edge-aligned PWM, one-shot option and per-channel wrap flags with maskable irq.
module pwm_multi_timer #(
  parameter int unsigned NCH       = 4,
  parameter int unsigned PWMBITS   = 8,
  parameter int unsigned PRESCBITS = 8,
  parameter int unsigned ABITS     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ABITS-1:0] addr,
  input  logic             wr,
  input  logic [15:0]      d,
  output logic [15:0]      q,
  output logic [NCH-1:0]   pwm_out,
  output logic             irq
);

  logic wr_ctrl, wr_presc, wr_irqen, wr_flags;
  logic tick;

  logic [NCH-1:0] en_q, en_d, os_q, os_d;
  logic [NCH-1:0] irqen_q, irqen_d, flags_q, flags_d;
  logic [NCH-1:0] pwm_q, pwm_d, wrap;

  logic [PRESCBITS-1:0] presc_q, presc_d, pc_q, pc_d;

  logic [PWMBITS-1:0] sh_per_q   [NCH];
  logic [PWMBITS-1:0] sh_per_d   [NCH];
  logic [PWMBITS-1:0] sh_duty_q  [NCH];
  logic [PWMBITS-1:0] sh_duty_d  [NCH];
  logic [PWMBITS-1:0] act_per_q  [NCH];
  logic [PWMBITS-1:0] act_per_d  [NCH];
  logic [PWMBITS-1:0] act_duty_q [NCH];
  logic [PWMBITS-1:0] act_duty_d [NCH];
  logic [PWMBITS-1:0] cnt_q      [NCH];
  logic [PWMBITS-1:0] cnt_d      [NCH];

  logic unused_d;
  assign unused_d = ^d;

  assign wr_ctrl  = wr && (addr == ABITS'(0));
  assign wr_presc = wr && (addr == ABITS'(1));
  assign wr_irqen = wr && (addr == ABITS'(2));
  assign wr_flags = wr && (addr == ABITS'(3));

  // A prescaler write restarts the divider and suppresses the tick of that cycle.
  assign tick = (pc_q == presc_q) && !wr_presc;

  always_comb begin
    pc_d    = (wr_presc || (pc_q == presc_q)) ? '0 : pc_q + 1'b1;
    presc_d = wr_presc ? d[PRESCBITS-1:0] : presc_q;
    irqen_d = wr_irqen ? d[NCH-1:0] : irqen_q;
  end

  always_comb begin
    wrap  = '0;
    pwm_d = '0;
    for (int i = 0; i < NCH; i++) begin
      wrap[i]       = en_q[i] && tick && (cnt_q[i] == act_per_q[i]);
      pwm_d[i]      = en_q[i] && (cnt_q[i] < act_duty_q[i]);
      cnt_d[i]      = cnt_q[i];
      act_per_d[i]  = act_per_q[i];
      act_duty_d[i] = act_duty_q[i];
      sh_per_d[i]   = sh_per_q[i];
      sh_duty_d[i]  = sh_duty_q[i];
      // Idle channels track the shadows so an enable starts with the latest values.
      if (!en_q[i] || wrap[i]) begin
        act_per_d[i]  = sh_per_q[i];
        act_duty_d[i] = sh_duty_q[i];
        cnt_d[i]      = '0;
      end else if (tick) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
      if (wr && (addr == ABITS'(4 + 2 * i))) sh_per_d[i] = d[PWMBITS-1:0];
      if (wr && (addr == ABITS'(5 + 2 * i))) sh_duty_d[i] = d[PWMBITS-1:0];
    end
    // CPU write to CTRL takes priority over a one-shot self-clear.
    en_d    = wr_ctrl ? d[NCH-1:0] : (en_q & ~(wrap & os_q));
    os_d    = wr_ctrl ? d[8+NCH-1:8] : os_q;
    flags_d = (flags_q & ~(wr_flags ? d[NCH-1:0] : '0)) | wrap;
  end

  always_comb begin
    q = '0;
    case (addr)
      ABITS'(0): begin
        q[NCH-1:0]   = en_q;
        q[8+NCH-1:8] = os_q;
      end
      ABITS'(1): q = 16'(presc_q);
      ABITS'(2): q[NCH-1:0] = irqen_q;
      ABITS'(3): q[NCH-1:0] = flags_q;
      default: ;
    endcase
    for (int i = 0; i < NCH; i++) begin
      if (addr == ABITS'(4 + 2 * i)) q = 16'(sh_per_q[i]);
      if (addr == ABITS'(5 + 2 * i)) q = 16'(sh_duty_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q    <= '0;
      os_q    <= '0;
      irqen_q <= '0;
      flags_q <= '0;
      pwm_q   <= '0;
      presc_q <= '0;
      pc_q    <= '0;
      for (int i = 0; i < NCH; i++) begin
        sh_per_q[i]   <= '0;
        sh_duty_q[i]  <= '0;
        act_per_q[i]  <= '0;
        act_duty_q[i] <= '0;
        cnt_q[i]      <= '0;
      end
    end else begin
      en_q       <= en_d;
      os_q       <= os_d;
      irqen_q    <= irqen_d;
      flags_q    <= flags_d;
      pwm_q      <= pwm_d;
      presc_q    <= presc_d;
      pc_q       <= pc_d;
      sh_per_q   <= sh_per_d;
      sh_duty_q  <= sh_duty_d;
      act_per_q  <= act_per_d;
      act_duty_q <= act_duty_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pwm_out = pwm_q;
  assign irq     = |(flags_q & irqen_q);

endmodule

// File: tb/tb_pwm_multi_timer.sv
// Bench for pwm_multi_timer: directed scenarios with literal expectations plus
// randomized register traffic checked every cycle against a behavioural model.
module tb_pwm_multi_timer;

  localparam int NCH  = 4;
  localparam int MASK = (1 << NCH) - 1;

  logic        clk;
  logic        reset;
  logic [3:0]  addr;
  logic        wr;
  logic [15:0] d;
  logic [15:0] q;
  logic [3:0]  pwm_out;
  logic        irq;

  pwm_multi_timer dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .wr      (wr),
    .d       (d),
    .q       (q),
    .pwm_out (pwm_out),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  // Behavioural model: register file plus, per channel, the position within
  // the current period and the period/duty latched at its start.
  int m_en, m_os, m_presc, m_pc, m_irqen, m_flags, m_pwm;
  int m_sp[NCH], m_sd[NCH], m_ap[NCH], m_ad[NCH], m_pos[NCH];

  function automatic void model_step();
    int  dv, wrapped, nxt_pwm;
    bit  tick;
    if (reset) begin
      m_en = 0; m_os = 0; m_presc = 0; m_pc = 0; m_irqen = 0; m_flags = 0; m_pwm = 0;
      for (int i = 0; i < NCH; i++) begin
        m_sp[i] = 0; m_sd[i] = 0; m_ap[i] = 0; m_ad[i] = 0; m_pos[i] = 0;
      end
      return;
    end
    dv      = int'(d);
    tick    = (m_pc == m_presc) && !(wr && addr == 1);
    wrapped = 0;
    nxt_pwm = 0;
    for (int i = 0; i < NCH; i++) begin
      if (m_en[i] && m_pos[i] < m_ad[i]) nxt_pwm |= (1 << i);
      if (!m_en[i]) begin
        m_pos[i] = 0; m_ap[i] = m_sp[i]; m_ad[i] = m_sd[i];
      end else if (tick) begin
        if (m_pos[i] == m_ap[i]) begin
          m_pos[i] = 0; m_ap[i] = m_sp[i]; m_ad[i] = m_sd[i];
          wrapped |= (1 << i);
        end else begin
          m_pos[i] = m_pos[i] + 1;
        end
      end
    end
    m_pwm   = nxt_pwm;
    m_pc    = ((wr && addr == 1) || m_pc == m_presc) ? 0 : m_pc + 1;
    m_flags = (m_flags & ~((wr && addr == 3) ? (dv & MASK) : 0)) | wrapped;
    if (wr && addr == 0) begin
      m_en = dv & MASK;
      m_os = (dv >> 8) & MASK;
    end else begin
      m_en = m_en & ~(wrapped & m_os);
    end
    if (wr && addr == 1) m_presc = dv & 'hff;
    if (wr && addr == 2) m_irqen = dv & MASK;
    for (int i = 0; i < NCH; i++) begin
      if (wr && addr == 4 + 2 * i) m_sp[i] = dv & 'hff;
      if (wr && addr == 5 + 2 * i) m_sd[i] = dv & 'hff;
    end
  endfunction

  function automatic int model_read(int a);
    if (a == 0) return m_en | (m_os << 8);
    if (a == 1) return m_presc;
    if (a == 2) return m_irqen;
    if (a == 3) return m_flags;
    for (int i = 0; i < NCH; i++) begin
      if (a == 4 + 2 * i) return m_sp[i];
      if (a == 5 + 2 * i) return m_sd[i];
    end
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("pwm_out", 32'(pwm_out), 32'(m_pwm));
      chk("irq", 32'(irq), 32'((m_flags & m_irqen) != 0));
      chk("q_read", 32'(q), 32'(model_read(int'(addr))));
    end
  end

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      wr   = 1'b0;
      addr = 4'($urandom_range(0, 15));
      cycle();
    end
  endtask

  task automatic wr_reg(input int a, input int v);
    addr = 4'(a);
    d    = 16'(v);
    wr   = 1'b1;
    cycle();
    wr   = 1'b0;
  endtask

  // Cycles until FLAGS[ch] reads 1, or -1 (reported) on timeout.
  task automatic wait_flag(input int ch, input int max, output int n);
    n    = -1;
    addr = 4'd3;
    wr   = 1'b0;
    for (int c = 1; c <= max; c++) begin
      cycle();
      if (q[ch]) begin
        n = c;
        break;
      end
    end
    if (n < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL flag_timeout: got no FLAGS[%0d] within %0d cycles, required one", ch, max);
    end
  endtask

  // Samples pwm_out[ch] after each of ncyc edges; optionally writes (wa,wd) on cycle wr_at.
  task automatic run_count(input int ch, input int ncyc, input int wr_at, input int wa,
                           input int wd, output int hi);
    hi = 0;
    for (int k = 1; k <= ncyc; k++) begin
      if (k == wr_at) begin
        addr = 4'(wa);
        d    = 16'(wd);
        wr   = 1'b1;
      end else begin
        wr   = 1'b0;
        addr = 4'd3;
      end
      cycle();
      wr = 1'b0;
      if (pwm_out[ch]) hi++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  initial begin
    int n, hi, a, v;
    reset = 1'b1;
    wr    = 1'b0;
    addr  = 4'd0;
    d     = 16'd0;
    cycle();
    cycle();
    reset  = 1'b0;
    cmp_on = 1'b1;
    chk("rst_pwm_out", 32'(pwm_out), 0);
    chk("rst_irq", 32'(irq), 0);
    for (int r = 0; r < 4; r++) begin
      addr = 4'(r);
      #1;
      chk("rst_reg", 32'(q), 0);
    end

    // Basic PWM, PRESC=0, period 10 clk, 3 high
    wr_reg(1, 0);
    wr_reg(4, 9);
    wr_reg(5, 3);
    wr_reg(0, 1);
    wait_flag(0, 30, n);
    wr_reg(3, 1);
    wait_flag(0, 30, n);
    chk("t1_flag_period", 32'(n + 1), 10);
    run_count(0, 10, 0, 0, 0, hi);
    chk("t1_high_clks", 32'(hi), 3);

    // Duty change mid-period applies only from the next period
    run_count(0, 10, 5, 5, 7, hi);
    chk("t3_cur_period_high", 32'(hi), 3);
    run_count(0, 10, 0, 0, 0, hi);
    chk("t3_next_period_high", 32'(hi), 7);

    // PRESC=3, DUTY>PERIOD -> constant high, 20 clk period; DUTY=0 from next wrap
    wr_reg(0, 0);
    wr_reg(1, 3);
    wr_reg(6, 4);
    wr_reg(7, 5);
    wr_reg(0, 2);
    wr_reg(3, 15);
    wait_flag(1, 40, n);
    wr_reg(3, 2);
    wait_flag(1, 40, n);
    chk("t2_flag_period", 32'(n + 1), 20);
    run_count(1, 20, 1, 7, 0, hi);
    chk("t2_const_high", 32'(hi), 20);
    run_count(1, 20, 0, 0, 0, hi);
    chk("t2_const_low", 32'(hi), 0);

    // One-shot on channel 2 with irq
    wr_reg(0, 0);
    wr_reg(1, 0);
    wr_reg(8, 5);
    wr_reg(2, 4);
    wr_reg(3, 15);
    wr_reg(0, 'h0404);
    wait_flag(2, 20, n);
    chk("t4_oneshot_len", 32'(n), 6);
    addr = 4'd0;
    #1;
    chk("t4_ctrl_after", 32'(q), 'h0400);
    chk("t4_irq_set", 32'(irq), 1);
    wr_reg(3, 4);
    chk("t4_irq_clr", 32'(irq), 0);

    // W1C coinciding with a wrap: set wins; then reset mid-period
    wr_reg(0, 0);
    wr_reg(4, 9);
    wr_reg(5, 3);
    wr_reg(0, 1);
    wr_reg(3, 15);
    wait_flag(0, 30, n);
    wr_reg(3, 1);
    idle(8);
    wr_reg(3, 1);
    addr = 4'd3;
    #1;
    chk("t5_w1c_vs_wrap", 32'(q[0]), 1);
    idle(1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("t5_rst_pwm", 32'(pwm_out), 0);
    for (int r = 0; r < 16; r++) begin
      addr = 4'(r);
      #1;
      chk("t5_rst_q", 32'(q), 0);
    end

    // All channels, randomized configuration and background register traffic
    wr_reg(1, $urandom_range(0, 3));
    for (int i = 0; i < NCH; i++) begin
      wr_reg(4 + 2 * i, $urandom_range(1, 40));
      wr_reg(5 + 2 * i, $urandom_range(0, 45));
    end
    wr_reg(2, $urandom_range(0, 15));
    wr_reg(0, 15);
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 29) == 0) begin
        a = $urandom_range(0, 15);
        v = int'($urandom_range(0, 65535));
        if (a == 1) v = v & 3;
        if (a == 0) v = 15 | (v & 'h0300);
        wr_reg(a, v);
      end else begin
        idle(1);
      end
    end

    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
